// File: rtl/gmii_frame_fifo.sv
// gmii_frame_fifo: single-clock GMII store-and-forward buffer.
// Frames are released only once complete and good; bad frames are dropped whole.
module gmii_frame_fifo #(
    parameter int DEPTH      = 2048,
    parameter int DESC_DEPTH = 8,
    parameter int IFG        = 12,
    parameter bit DROP_ERR   = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                            gmii_clk,
    input  logic                            gmii_rstn,
    input  logic [7:0]                      gmii_rxd,
    input  logic                            gmii_rx_dv,
    input  logic                            gmii_rx_er,
    output logic [7:0]                      gmii_txd,
    output logic                            gmii_tx_en,
    output logic                            gmii_tx_er,
    output logic [$clog2(DESC_DEPTH+1)-1:0] frame_cnt,
    output logic [CNT_W-1:0]                drop_cnt,
    output logic                            drop_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DESC_DEPTH);
    localparam int FW = $clog2(DESC_DEPTH + 1);
    localparam int GW = $clog2(IFG + 1);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
    state_t state, state_nxt;

    logic [8:0]    ram  [DEPTH];
    logic [AW:0]   desc [DESC_DEPTH];
    logic [AW:0]   wr_ptr, cmt_ptr, rd_ptr, rd_ptr_nxt, used, desc_end;
    logic [DW-1:0] dwp, drp;
    logic [GW-1:0] gcnt;
    logic armed, act, drop_full, ovf, err;
    logic start, in_byte, fend, bad, desc_full, dfull_eff, ovf_eff, ram_full;
    logic wr_en, push, pop, rd_go, last, gap_done;

    // armed stays low until dv is seen low, so a frame already running at reset release is ignored
    always_comb begin
        start      = gmii_rx_dv && !act && armed;
        in_byte    = gmii_rx_dv && (act || armed);
        fend       = !gmii_rx_dv && act;
        bad        = ovf || err || drop_full;
        desc_full  = frame_cnt == FW'(DESC_DEPTH);
        dfull_eff  = start ? desc_full : drop_full;
        ovf_eff    = !start && ovf;
        desc_end   = desc[drp];
        rd_go      = state == LOAD || state == SEND;
        last       = rd_ptr + ONE == desc_end;
        pop        = rd_go && last;
        push       = fend && !bad;
        rd_ptr_nxt = rd_go ? rd_ptr + ONE : rd_ptr;
        used       = wr_ptr - rd_ptr_nxt;
        ram_full   = used == FULL;
        wr_en      = in_byte && !dfull_eff && !ovf_eff && !ram_full;
        gap_done   = gcnt == GW'(IFG);
        state_nxt  = rd_go ? (last ? GAP : SEND) :
                     (state == GAP && !gap_done) ? GAP :
                     (frame_cnt != '0) ? LOAD : IDLE;
    end

    always_ff @(posedge gmii_clk) begin
        if (wr_en) ram[wr_ptr[AW-1:0]] <= {gmii_rx_er, gmii_rxd};
        if (push) desc[dwp] <= wr_ptr;
    end

    // the tx output register is loaded straight from RAM so the first byte follows LOAD
    always_ff @(posedge gmii_clk or negedge gmii_rstn) begin
        if (!gmii_rstn) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            rd_ptr     <= '0;
            dwp        <= '0;
            drp        <= '0;
            gcnt       <= '0;
            armed      <= 1'b0;
            act        <= 1'b0;
            drop_full  <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
            gmii_txd   <= '0;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= armed || !gmii_rx_dv;
            act   <= in_byte;
            if (!gmii_rx_dv) begin
                drop_full <= 1'b0;
                ovf       <= 1'b0;
                err       <= 1'b0;
            end else if (in_byte) begin
                drop_full <= dfull_eff;
                ovf       <= ovf_eff || (!dfull_eff && ram_full);
                err       <= (!start && err) || (DROP_ERR && gmii_rx_er);
            end
            wr_ptr     <= wr_en ? wr_ptr + ONE : (fend && bad) ? cmt_ptr : wr_ptr;
            cmt_ptr    <= push ? wr_ptr : cmt_ptr;
            dwp        <= dwp + DW'(push);
            drp        <= drp + DW'(pop);
            rd_ptr     <= rd_ptr_nxt;
            gcnt       <= (state == GAP && !gap_done) ? gcnt + GW'(1) : '0;
            frame_cnt  <= frame_cnt + FW'(push) - FW'(pop);
            drop_cnt   <= drop_cnt + CNT_W'(fend && bad);
            drop_pulse <= fend && bad;
            gmii_tx_en <= rd_go;
            gmii_txd   <= rd_go ? ram[rd_ptr[AW-1:0]][7:0] : '0;
            gmii_tx_er <= rd_go && !DROP_ERR && ram[rd_ptr[AW-1:0]][8];
        end
    end
endmodule

// File: tb/tb_gmii_frame_fifo.sv
// tb_gmii_frame_fifo: directed bench over four parameterisations sharing one rx stimulus.
// u0 default, u1 DROP_ERR=0, u2 DEPTH=64, u3 DESC_DEPTH=2 IFG=200.
module tb_gmii_frame_fifo;
    logic gmii_clk = 1'b0;
    logic gmii_rstn = 1'b0;
    logic [7:0] rxd = '0;
    logic dv = 1'b0;
    logic rxer = 1'b0;
    logic [7:0]  txd [4];
    logic        tx_en [4];
    logic        tx_er [4];
    logic        dpulse [4];
    logic [15:0] dcnt [4];
    logic [3:0]  fc [3];
    logic [1:0]  fc3;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [8:0] bytes [4][$];
    int starts [4][$];
    int lens [4][$];
    int pulses [4];
    int idle_bad [4];
    logic prev_en [4];

    always #5 gmii_clk = ~gmii_clk;
    always @(posedge gmii_clk) cyc <= cyc + 1;

    gmii_frame_fifo #(.DROP_ERR(1'b1)) u0 (
        .gmii_clk(gmii_clk), .gmii_rstn(gmii_rstn), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(rxer),
        .gmii_txd(txd[0]), .gmii_tx_en(tx_en[0]), .gmii_tx_er(tx_er[0]),
        .frame_cnt(fc[0]), .drop_cnt(dcnt[0]), .drop_pulse(dpulse[0]));
    gmii_frame_fifo #(.DROP_ERR(1'b0)) u1 (
        .gmii_clk(gmii_clk), .gmii_rstn(gmii_rstn), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(rxer),
        .gmii_txd(txd[1]), .gmii_tx_en(tx_en[1]), .gmii_tx_er(tx_er[1]),
        .frame_cnt(fc[1]), .drop_cnt(dcnt[1]), .drop_pulse(dpulse[1]));
    gmii_frame_fifo #(.DEPTH(64)) u2 (
        .gmii_clk(gmii_clk), .gmii_rstn(gmii_rstn), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(rxer),
        .gmii_txd(txd[2]), .gmii_tx_en(tx_en[2]), .gmii_tx_er(tx_er[2]),
        .frame_cnt(fc[2]), .drop_cnt(dcnt[2]), .drop_pulse(dpulse[2]));
    gmii_frame_fifo #(.DESC_DEPTH(2), .IFG(200)) u3 (
        .gmii_clk(gmii_clk), .gmii_rstn(gmii_rstn), .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(rxer),
        .gmii_txd(txd[3]), .gmii_tx_en(tx_en[3]), .gmii_tx_er(tx_er[3]),
        .frame_cnt(fc3), .drop_cnt(dcnt[3]), .drop_pulse(dpulse[3]));

    // record tx bursts (start cycle, length, bytes) and drop pulses per instance
    always @(negedge gmii_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (tx_en[i]) begin
                if (!prev_en[i] || lens[i].size() == 0) begin
                    starts[i].push_back(cyc);
                    lens[i].push_back(0);
                end
                lens[i][lens[i].size()-1] += 1;
                bytes[i].push_back({tx_er[i], txd[i]});
            end else if (txd[i] != 8'h00 || tx_er[i]) idle_bad[i]++;
            if (dpulse[i]) pulses[i]++;
            prev_en[i] = tx_en[i];
        end
    end

    task automatic tick;
        @(posedge gmii_clk);
        #1;
    endtask

    task automatic clear_mon;
        for (int i = 0; i < 4; i++) begin
            bytes[i].delete();
            starts[i].delete();
            lens[i].delete();
            pulses[i] = 0;
            idle_bad[i] = 0;
        end
    endtask

    task automatic apply_reset;
        gmii_rstn = 1'b0;
        dv = 1'b0;
        rxer = 1'b0;
        rxd = '0;
        repeat (3) tick();
        gmii_rstn = 1'b1;
        repeat (2) tick();
        clear_mon();
    endtask

    task automatic send_frame(input int n, input int base, input int er_at);
        for (int k = 0; k < n; k++) begin
            rxd = 8'(base + k);
            dv = 1'b1;
            rxer = (k == er_at);
            tick();
        end
        dv = 1'b0;
        rxer = 1'b0;
        rxd = '0;
        tick();
    endtask

    function automatic int burst_errs(input int i, input int off, input int n, input int base, input int er_at);
        int e = 0;
        for (int k = 0; k < n; k++) begin
            logic [8:0] want;
            want = {(k == er_at), 8'(base + k)};
            if (off + k >= bytes[i].size() || bytes[i][off+k] !== want) e++;
        end
        return e;
    endfunction

    task automatic test_reset;
        repeat (2) tick();
        checks++; if ({tx_en[0], tx_er[0], txd[0], dpulse[0]} !== 11'd0) begin failures++; $display("FAIL reset_tx: got %h expected 0", {tx_en[0], tx_er[0], txd[0], dpulse[0]}); end
        checks++; if (fc[0] !== 4'd0) begin failures++; $display("FAIL reset_frame_cnt: got %0d expected 0", fc[0]); end
        checks++; if (dcnt[0] !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt: got %0d expected 0", dcnt[0]); end
        checks++; if ({fc3, dcnt[3], tx_en[3]} !== 19'd0) begin failures++; $display("FAIL reset_u3: got %h expected 0", {fc3, dcnt[3], tx_en[3]}); end
        gmii_rstn = 1'b1;
        repeat (3) tick();
        checks++; if ({tx_en[0], fc[0], dcnt[0], dpulse[0]} !== 22'd0) begin failures++; $display("FAIL post_reset_idle: got %h expected 0", {tx_en[0], fc[0], dcnt[0], dpulse[0]}); end
    endtask

    task automatic test_single;
        int ce;
        apply_reset();
        send_frame(64, 0, -1);
        ce = cyc;
        checks++; if (fc[0] !== 4'd1) begin failures++; $display("FAIL single_frame_cnt_commit: got %0d expected 1", fc[0]); end
        repeat (80) tick();
        checks++; if (starts[0].size() != 1) begin failures++; $display("FAIL single_bursts: got %0d expected 1", starts[0].size()); end
        checks++; if (starts[0][0] != ce + 2) begin failures++; $display("FAIL single_latency: got %0d expected %0d", starts[0][0], ce + 2); end
        checks++; if (lens[0][0] != 64) begin failures++; $display("FAIL single_len: got %0d expected 64", lens[0][0]); end
        checks++; if (burst_errs(0, 0, 64, 0, -1) != 0) begin failures++; $display("FAIL single_data: got %0d bad bytes expected 0", burst_errs(0, 0, 64, 0, -1)); end
        checks++; if (fc[0] !== 4'd0) begin failures++; $display("FAIL single_frame_cnt_done: got %0d expected 0", fc[0]); end
        checks++; if (idle_bad[0] != 0) begin failures++; $display("FAIL single_idle_zero: got %0d expected 0", idle_bad[0]); end
    endtask

    task automatic test_back_to_back;
        int bad_len, errs;
        apply_reset();
        for (int f = 0; f < 3; f++) send_frame(60, f * 64, -1);
        repeat (250) tick();
        checks++; if (starts[0].size() != 3) begin failures++; $display("FAIL b2b_bursts: got %0d expected 3", starts[0].size()); end
        bad_len = 0;
        errs = 0;
        for (int f = 0; f < 3; f++) begin
            if (lens[0][f] != 60) bad_len++;
            errs += burst_errs(0, f * 60, 60, f * 64, -1);
        end
        checks++; if (bad_len != 0) begin failures++; $display("FAIL b2b_len: got %0d wrong bursts expected 0", bad_len); end
        checks++; if (errs != 0) begin failures++; $display("FAIL b2b_data: got %0d bad bytes expected 0", errs); end
        for (int f = 0; f < 2; f++) begin
            checks++; if (starts[0][f+1] - starts[0][f] - 60 != 13) begin failures++; $display("FAIL b2b_gap%0d: got %0d expected 13", f, starts[0][f+1] - starts[0][f] - 60); end
        end
        checks++; if (dcnt[0] !== 16'd0) begin failures++; $display("FAIL b2b_drop_cnt: got %0d expected 0", dcnt[0]); end
    endtask

    task automatic test_error;
        apply_reset();
        send_frame(100, 0, 50);
        send_frame(64, 160, -1);
        repeat (200) tick();
        checks++; if (pulses[0] != 1) begin failures++; $display("FAIL err_drop_pulse: got %0d expected 1", pulses[0]); end
        checks++; if (dcnt[0] !== 16'd1) begin failures++; $display("FAIL err_drop_cnt: got %0d expected 1", dcnt[0]); end
        checks++; if (starts[0].size() != 1 || lens[0][0] != 64) begin failures++; $display("FAIL err_good_burst: got %0d bursts len %0d expected 1 len 64", starts[0].size(), lens[0][0]); end
        checks++; if (burst_errs(0, 0, 64, 160, -1) != 0) begin failures++; $display("FAIL err_good_data: got %0d bad bytes expected 0", burst_errs(0, 0, 64, 160, -1)); end
        checks++; if (starts[1].size() != 2 || lens[1][0] != 100) begin failures++; $display("FAIL keep_err_burst: got %0d bursts len %0d expected 2 len 100", starts[1].size(), lens[1][0]); end
        checks++; if (burst_errs(1, 0, 100, 0, 50) != 0) begin failures++; $display("FAIL keep_err_data: got %0d bad bytes expected 0", burst_errs(1, 0, 100, 0, 50)); end
        checks++; if (burst_errs(1, 100, 64, 160, -1) != 0) begin failures++; $display("FAIL keep_err_second: got %0d bad bytes expected 0", burst_errs(1, 100, 64, 160, -1)); end
        checks++; if (dcnt[1] !== 16'd0) begin failures++; $display("FAIL keep_err_drop_cnt: got %0d expected 0", dcnt[1]); end
    endtask

    task automatic test_overflow;
        apply_reset();
        send_frame(50, 0, -1);
        repeat (80) tick();
        clear_mon();
        send_frame(80, 64, -1);
        send_frame(20, 192, -1);
        repeat (60) tick();
        checks++; if (dcnt[2] !== 16'd1) begin failures++; $display("FAIL ovf_drop_cnt: got %0d expected 1", dcnt[2]); end
        checks++; if (pulses[2] != 1) begin failures++; $display("FAIL ovf_drop_pulse: got %0d expected 1", pulses[2]); end
        checks++; if (starts[2].size() != 1 || lens[2][0] != 20) begin failures++; $display("FAIL ovf_burst: got %0d bursts len %0d expected 1 len 20", starts[2].size(), lens[2][0]); end
        checks++; if (burst_errs(2, 0, 20, 192, -1) != 0) begin failures++; $display("FAIL ovf_wrap_data: got %0d bad bytes expected 0", burst_errs(2, 0, 20, 192, -1)); end
    endtask

    task automatic test_desc_full;
        int bad_len;
        apply_reset();
        send_frame(16, 0, -1);
        repeat (20) tick();
        for (int f = 1; f <= 4; f++) send_frame(16, f * 16, -1);
        checks++; if (fc3 !== 2'd2) begin failures++; $display("FAIL qfull_frame_cnt: got %0d expected 2", fc3); end
        checks++; if (dcnt[3] !== 16'd2) begin failures++; $display("FAIL qfull_drop_cnt: got %0d expected 2", dcnt[3]); end
        repeat (450) tick();
        checks++; if (pulses[3] != 2) begin failures++; $display("FAIL qfull_drop_pulse: got %0d expected 2", pulses[3]); end
        checks++; if (starts[3].size() != 3) begin failures++; $display("FAIL qfull_bursts: got %0d expected 3", starts[3].size()); end
        bad_len = 0;
        for (int f = 0; f < 3; f++) if (lens[3][f] != 16) bad_len++;
        checks++; if (bad_len != 0) begin failures++; $display("FAIL qfull_len: got %0d wrong bursts expected 0", bad_len); end
        checks++; if (burst_errs(3, 16, 16, 16, -1) + burst_errs(3, 32, 16, 32, -1) != 0) begin failures++; $display("FAIL qfull_data: got %0d bad bytes expected 0", burst_errs(3, 16, 16, 16, -1) + burst_errs(3, 32, 16, 32, -1)); end
        checks++; if (starts[3][2] - starts[3][1] - 16 != 201) begin failures++; $display("FAIL qfull_gap: got %0d expected 201", starts[3][2] - starts[3][1] - 16); end
        checks++; if (fc3 !== 2'd0) begin failures++; $display("FAIL qfull_frame_cnt_done: got %0d expected 0", fc3); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        send_frame(20, 0, 5);
        send_frame(30, 80, -1);
        for (int k = 0; k < 40; k++) begin
            rxd = 8'(100 + k);
            dv = 1'b1;
            if (k == 30) begin
                checks++; if (dcnt[0] !== 16'd1 || tx_en[0] !== 1'b1) begin failures++; $display("FAIL mid_pre_state: got drop %0d en %0b expected 1 1", dcnt[0], tx_en[0]); end
                gmii_rstn = 1'b0;
                #1;
                checks++; if ({tx_en[0], tx_er[0], txd[0], dpulse[0]} !== 11'd0) begin failures++; $display("FAIL mid_reset_tx: got %h expected 0", {tx_en[0], tx_er[0], txd[0], dpulse[0]}); end
                checks++; if ({fc[0], dcnt[0]} !== 20'd0) begin failures++; $display("FAIL mid_reset_counts: got %h expected 0", {fc[0], dcnt[0]}); end
            end
            if (k == 31) gmii_rstn = 1'b1;
            if (k == 32) clear_mon();
            tick();
        end
        dv = 1'b0;
        repeat (3) tick();
        checks++; if (dcnt[0] !== 16'd0 || pulses[0] != 0 || fc[0] !== 4'd0) begin failures++; $display("FAIL mid_ignored: got drop %0d pulses %0d frames %0d expected 0 0 0", dcnt[0], pulses[0], fc[0]); end
        send_frame(32, 144, -1);
        repeat (60) tick();
        checks++; if (starts[0].size() != 1 || lens[0][0] != 32) begin failures++; $display("FAIL mid_next_burst: got %0d bursts len %0d expected 1 len 32", starts[0].size(), lens[0][0]); end
        checks++; if (burst_errs(0, 0, 32, 144, -1) != 0) begin failures++; $display("FAIL mid_next_data: got %0d bad bytes expected 0", burst_errs(0, 0, 32, 144, -1)); end
        checks++; if (dcnt[0] !== 16'd0 || idle_bad[0] != 0) begin failures++; $display("FAIL mid_final: got drop %0d idle_bad %0d expected 0 0", dcnt[0], idle_bad[0]); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_error();
        test_overflow();
        test_desc_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
